uart_frame_decoder: RTL

//  Downstream consumer of the multi-byte UART receiver. Takes each packed frame word plus its one-cycle done strobe,

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_frame_decoder_if.sv | 25 ++
 rtl/uart_frame_decoder_sync_fifo.sv | 52 +++++
 rtl/uart_frame_decoder.sv | 93 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing constants and the additive frame checksum,
// used by both the RX-side decoder and the TX-side encoder.
package uart_pkg;

  localparam logic [7:0] FRAME_HEADER    = 8'hA5;
  localparam int         MAX_FRAME_BYTES = 32;

  // Sums bytes 0..n-1 modulo 256; callers zero-extend shorter frames.
  function automatic logic [7:0] frame_sum(input logic [MAX_FRAME_BYTES*8-1:0] bytes,
                                           input int n);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_FRAME_BYTES; i++) begin
      if (i < n) acc = acc + bytes[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Frame input strobe and command output handshake of the frame decoder.
// cmd_* is valid/ready: a transfer happens on any edge with cmd_valid && cmd_ready;
// while cmd_valid is high and cmd_ready low, cmd_addr/cmd_data are held stable.
interface uart_frame_decoder_if #(
  parameter int FRAME_BYTES = 4
) ();
  localparam int DATA_W = (FRAME_BYTES - 3) * 8;

  logic                     frame_valid;
  logic [FRAME_BYTES*8-1:0] frame_data;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [7:0]               cmd_addr;
  logic [DATA_W-1:0]        cmd_data;

  modport master (
    output frame_valid, frame_data, cmd_ready,
    input  cmd_valid, cmd_addr, cmd_data
  );

  modport slave (
    input  frame_valid, frame_data, cmd_ready,
    output cmd_valid, cmd_addr, cmd_data
  );
endinterface

// File: rtl/uart_frame_decoder_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_frame_decoder.sv
// Checks header and checksum of received UART frames, queues good commands
// in a FIFO and counts rejected or dropped frames in saturating counters.
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter int         FRAME_BYTES = 4,
  parameter logic [7:0] HEADER      = FRAME_HEADER,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  uart_frame_decoder_if.slave         bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  hdr_err_cnt,
  output logic [7:0]                  sum_err_cnt,
  output logic [7:0]                  ovf_err_cnt
);
  localparam int DATA_W = (FRAME_BYTES - 3) * 8;
  localparam int FW     = FRAME_BYTES * 8;

  logic                         s1_valid;
  logic [FW-1:0]                s1_data;
  logic [MAX_FRAME_BYTES*8-1:0] s1_ext;
  logic [7:0]                   sum;
  logic                         hdr_ok;
  logic                         sum_ok;
  logic                         good;
  logic                         push;
  logic                         pop;
  logic                         full;
  logic                         empty;
  logic [DATA_W+7:0]            wr_data;
  logic [DATA_W+7:0]            rd_data;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= bus.frame_valid;
      if (bus.frame_valid) s1_data <= bus.frame_data;
    end
  end

  always_comb begin
    s1_ext         = '0;
    s1_ext[FW-1:0] = s1_data;
  end

  assign sum     = frame_sum(s1_ext, FRAME_BYTES - 1);
  assign hdr_ok  = (s1_data[7:0] == HEADER);
  assign sum_ok  = (sum == s1_data[FW-1 -: 8]);
  assign good    = s1_valid && hdr_ok && sum_ok;
  assign pop     = bus.cmd_valid && bus.cmd_ready;
  // Full FIFO still accepts when the head leaves on the same edge.
  assign push    = good && (!full || pop);
  assign wr_data = {s1_data[15:8], s1_data[FW-9:16]};

  sync_fifo #(
    .WIDTH (DATA_W + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign bus.cmd_valid = !empty;
  assign bus.cmd_addr  = rd_data[DATA_W+7:DATA_W];
  assign bus.cmd_data  = rd_data[DATA_W-1:0];

  // Header failure takes priority, so each frame bumps at most one counter.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      hdr_err_cnt <= '0;
      sum_err_cnt <= '0;
      ovf_err_cnt <= '0;
    end else begin
      if (s1_valid && !hdr_ok && hdr_err_cnt != 8'hFF)
        hdr_err_cnt <= hdr_err_cnt + 8'd1;
      if (s1_valid && hdr_ok && !sum_ok && sum_err_cnt != 8'hFF)
        sum_err_cnt <= sum_err_cnt + 8'd1;
      if (good && !push && ovf_err_cnt != 8'hFF)
        ovf_err_cnt <= ovf_err_cnt + 8'd1;
    end
  end
endmodule
